// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART frame decoder and the CPU read path.
// Stores {ferr, byte} per entry and presents a registered 32-bit read word with status flags.
module uart_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          wr_ferr,
    input  logic          rd_en,
    input  logic          clr_flags,
    input  logic          irq_en,
    output logic [31:0]   rd_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          overrun,
    output logic          underflow,
    output logic          irq
);

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_CNT    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic          push_ok;
    logic          pop_ok;
    logic          push_drop;
    logic          pop_under;

    assign empty       = (count == '0);
    assign full        = (count == DEPTH_CNT);
    assign almost_full = (count >= AF_CNT);

    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign push_ok   = wr_en & (~full | rd_en);
    assign pop_ok    = rd_en & ~empty;
    assign push_drop = wr_en & full & ~rd_en;
    assign pop_under = rd_en & empty;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        unique case ({push_ok, pop_ok})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // NOTE: storage is deliberately left out of reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {wr_ferr, wr_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            overrun   <= 1'b0;
            underflow <= 1'b0;
            irq       <= 1'b0;
        end else begin
            count <= count_next;
            irq   <= irq_en & (count_next != '0);

            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            if (pop_ok) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= {22'b0, 1'b1, mem[rd_ptr]};
            end else if (pop_under) begin
                rd_data <= '0;
            end

            // Setting a sticky flag takes priority over clearing it in the same cycle.
            if (push_drop) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end

            if (pop_under) begin
                underflow <= 1'b1;
            end else if (clr_flags) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH    = 16;
    localparam int AW       = 4;
    localparam int AF_LEVEL = 12;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          wr_ferr;
    logic          rd_en;
    logic          clr_flags;
    logic          irq_en;
    logic [31:0]   rd_data;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          overrun;
    logic          underflow;
    logic          irq;

    int n_total;
    int n_pass;

    // Reference model state
    logic [8:0]  q[$];
    logic [31:0] m_rd;
    logic        m_over;
    logic        m_under;
    logic        m_irq;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .AF_LEVEL(AF_LEVEL)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_ferr     (wr_ferr),
        .rd_en       (rd_en),
        .clr_flags   (clr_flags),
        .irq_en      (irq_en),
        .rd_data     (rd_data),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overrun     (overrun),
        .underflow   (underflow),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_rd    = '0;
        m_over  = 1'b0;
        m_under = 1'b0;
        m_irq   = 1'b0;
    endtask

    // Drives one clock cycle of inputs, advances the model, returns 1 ns after the edge.
    task automatic step(input logic we, input logic [7:0] wd, input logic wf,
                        input logic re, input logic clr);
        bit was_full, was_empty, set_o, set_u;
        wr_en     = we;
        wr_data   = wd;
        wr_ferr   = wf;
        rd_en     = re;
        clr_flags = clr;
        @(posedge clk);
        #1;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        set_o = 1'b0;
        set_u = 1'b0;
        if (re && !was_empty) m_rd = {22'b0, 1'b1, q.pop_front()};
        else if (re) begin
            m_rd  = '0;
            set_u = 1'b1;
        end
        if (we && (!was_full || re)) q.push_back({wf, wd});
        else if (we) set_o = 1'b1;
        m_over  = set_o ? 1'b1 : (clr ? 1'b0 : m_over);
        m_under = set_u ? 1'b1 : (clr ? 1'b0 : m_under);
        m_irq   = irq_en && (q.size() != 0);
        wr_en     = 1'b0;
        wr_data   = '0;
        wr_ferr   = 1'b0;
        rd_en     = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if ({count, empty, full, overrun, underflow, irq} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) $display("FAIL reset_flags: got cnt=%0d e=%b f=%b o=%b u=%b i=%b expected cnt=0 e=1 f=0 o=0 u=0 i=0", count, empty, full, overrun, underflow, irq);
        else n_pass++;
        n_total++;
        if (rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h expected 00000000", rd_data);
        else n_pass++;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({count, empty, irq} !== {5'd3, 1'b0, 1'b1}) $display("FAIL basic_after_push: got cnt=%0d e=%b i=%b expected cnt=3 e=0 i=1", count, empty, irq);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            n_total++;
            if (rd_data !== 32'h241 + 32'(i)) $display("FAIL basic_pop%0d: got %h expected %h", i, rd_data, 32'h241 + 32'(i));
            else n_pass++;
        end
        n_total++;
        if ({empty, irq} !== 2'b10) $display("FAIL basic_drained: got e=%b i=%b expected e=1 i=0", empty, irq);
        else n_pass++;
    endtask

    task automatic test_full_overrun();
        int af_errs;
        af_errs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (almost_full !== (i + 1 >= AF_LEVEL)) af_errs++;
        end
        n_total++;
        if (af_errs != 0) $display("FAIL almost_full_threshold: got %0d wrong cycles expected 0", af_errs);
        else n_pass++;
        n_total++;
        if ({full, count} !== {1'b1, 5'd16}) $display("FAIL full_flag: got f=%b cnt=%0d expected f=1 cnt=16", full, count);
        else n_pass++;
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({overrun, count} !== {1'b1, 5'd16}) $display("FAIL overrun_set: got o=%b cnt=%0d expected o=1 cnt=16", overrun, count);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            n_total++;
            if (rd_data !== 32'h200 + 32'(i)) $display("FAIL full_pop%0d: got %h expected %h", i, rd_data, 32'h200 + 32'(i));
            else n_pass++;
        end
        n_total++;
        if ({empty, underflow} !== 2'b10) $display("FAIL full_drained: got e=%b u=%b expected e=1 u=0", empty, underflow);
        else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b expected 0", overrun);
        else n_pass++;
    endtask

    task automatic test_full_simultaneous();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        n_total++;
        if ({count, overrun, rd_data} !== {5'd16, 1'b0, 32'h200}) $display("FAIL full_push_pop: got cnt=%0d o=%b rd=%h expected cnt=16 o=0 rd=00000200", count, overrun, rd_data);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_total++;
        if ({rd_data, empty} !== {32'h2AA, 1'b1}) $display("FAIL wrap_last_pop: got rd=%h e=%b expected rd=000002aa e=1", rd_data, empty);
        else n_pass++;
    endtask

    task automatic test_underflow();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_total++;
        if ({rd_data, underflow} !== {32'h0, 1'b1}) $display("FAIL underflow_set: got rd=%h u=%b expected rd=00000000 u=1", rd_data, underflow);
        else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        n_total++;
        if (underflow !== 1'b1) $display("FAIL underflow_set_wins: got %b expected 1", underflow);
        else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (underflow !== 1'b0) $display("FAIL underflow_clear: got %b expected 0", underflow);
        else n_pass++;
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        n_total++;
        if ({count, underflow, rd_data[8]} !== {5'd1, 1'b1, 1'b0}) $display("FAIL empty_push_pop: got cnt=%0d u=%b valid=%b expected cnt=1 u=1 valid=0", count, underflow, rd_data[8]);
        else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        n_total++;
        if ({rd_data, underflow} !== {32'h277, 1'b0}) $display("FAIL empty_push_pop_drain: got rd=%h u=%b expected rd=00000277 u=0", rd_data, underflow);
        else n_pass++;
    endtask

    task automatic test_ferr();
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        n_total++;
        if ({count, overrun, underflow} !== {5'd1, 1'b0, 1'b0}) $display("FAIL ferr_push: got cnt=%0d o=%b u=%b expected cnt=1 o=0 u=0", count, overrun, underflow);
        else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_total++;
        if (rd_data !== 32'h355) $display("FAIL ferr_pop: got %h expected 00000355", rd_data);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        logic we, re, clr, wf;
        logic [7:0] wd;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            we  = ($urandom_range(0, 99) < 55);
            re  = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 99) < 5);
            wf  = ($urandom_range(0, 99) < 15);
            wd  = 8'($urandom);
            irq_en = ($urandom_range(0, 99) < 85);
            step(we, wd, wf, re, clr);
            n_total++;
            if ({rd_data, count, empty, full, almost_full, overrun, underflow, irq} !==
                {m_rd, 5'(q.size()), q.size() == 0, q.size() == DEPTH, q.size() >= AF_LEVEL, m_over, m_under, m_irq}) begin
                errs++;
                if (errs <= 5) $display("FAIL random_cycle%0d: got rd=%h cnt=%0d o=%b u=%b i=%b expected rd=%h cnt=%0d o=%b u=%b i=%b",
                                        i, rd_data, count, overrun, underflow, irq, m_rd, q.size(), m_over, m_under, m_irq);
            end else n_pass++;
        end
        irq_en = 1'b1;
        // Drain so later scenarios start from a known empty state.
        while (q.size() != 0) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_total++;
        if ({rd_data, count, irq} !== {32'h2C0, 5'd4, 1'b1}) $display("FAIL pre_reset: got rd=%h cnt=%0d i=%b expected rd=000002c0 cnt=4 i=1", rd_data, count, irq);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({rd_data, count, irq} !== {32'h0, 5'd0, 1'b0}) $display("FAIL async_reset: got rd=%h cnt=%0d i=%b expected rd=00000000 cnt=0 i=0", rd_data, count, irq);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_total++;
        if (rd_data !== 32'h210) $display("FAIL post_reset_pop: got %h expected 00000210", rd_data);
        else n_pass++;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        wr_ferr   = 1'b0;
        rd_en     = 1'b0;
        clr_flags = 1'b0;
        irq_en    = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_basic();
        test_full_overrun();
        test_full_simultaneous();
        test_underflow();
        test_ferr();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer between the UART receive datapath (10-bit frame to 8-bit byte) and the CPU bus read path.
- Absorbs received bytes while the CPU is busy. Provides a registered 32-bit read word plus status flags: empty, full, almost-full, sticky overrun, sticky underflow, and a level interrupt.
- Removes the single-byte hold limitation of the receive path, so back-to-back frames at high baud settings are not lost.

Parameters:
- DEPTH, 16, number of byte entries; power of two, 4..256
- AW, 4, pointer width; equals log2(DEPTH)
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  one-cycle pulse from receiver: byte complete
- wr_data  in  8  received byte, valid with wr_en
- wr_ferr  in  1  framing error (stop bit low) for this byte, valid with wr_en
- rd_en  in  1  one-cycle pop request from bus-side control
- clr_flags  in  1  clears sticky overrun/underflow
- irq_en  in  1  interrupt enable
- rd_data  out  32  {22'b0, rd_valid, rd_ferr, rd_byte[7:0]}
- count  out  AW+1  current occupancy, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_LEVEL
- overrun  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a pop was attempted while empty
- irq  out  1  registered; irq_en & ~empty

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, overrun=0, underflow=0, irq=0. Storage contents are don't-care.
- Reset mid-operation discards all buffered data. After reset deasserts, the next push lands at entry 0.
- Storage: DEPTH x 9 bits {ferr, byte}. Pointers are AW bits and wrap modulo DEPTH. Occupancy is kept in the separate count register (full/empty are not derived from pointers).
- Push accepted when wr_en & (~full | rd_en): entry written at wr_ptr, wr_ptr+1.
- Push while full without pop: byte dropped, overrun<=1, pointers and count unchanged.
- Pop accepted when rd_en & ~empty; rd_ptr+1.
  - rd_data <= {22'b0, 1'b1, mem[rd_ptr]} on the same edge.
  - Read latency is 1 cycle: data is visible the cycle after rd_en.
- Pop while empty: rd_data <= 0 (rd_valid=0), underflow<=1, no pointer change.
- rd_data holds its last value between pops. It is not updated by pushes.
- Count update per edge: +1 (push only), -1 (pop only), 0 (both or neither).
- Simultaneous push and pop:
  - When full: both accepted, count stays DEPTH, no overrun.
  - When empty: push accepted, pop rejected (underflow set, rd_valid=0), count becomes 1. There is no fall-through.
- clr_flags clears overrun and underflow. If a set condition occurs in the same cycle, set wins.
- empty, full, almost_full are combinational from count. irq is registered from the next-state count, so it asserts the cycle after the first push is accepted.
- wr_ferr is stored per byte. A framing error never blocks the push.
- rd_en and wr_en are treated as single-cycle pulses. Holding either high pushes or pops once per cycle.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 on consecutive cycles -> count=3, empty=0, irq=1 (with irq_en=1); three pops -> rd_data=0x241, 0x242, 0x243, each one cycle after its rd_en; empty=1.
- Push 16 bytes 0x00..0x0F -> full=1, almost_full asserted from the 12th push; 17th push 0xFF -> overrun=1, count=16; pop all -> 0x200..0x20F in order, 0xFF absent.
- Full FIFO, push 0xAA with simultaneous pop -> count stays 16, overrun=0, popped word=0x200; wrap check: the final pop returns 0x2AA.
- Empty FIFO, rd_en alone -> rd_data=0, underflow=1; clr_flags with a simultaneous empty pop -> underflow stays 1; clr_flags alone next cycle -> 0.
- Push 0x55 with wr_ferr=1 -> pop returns 0x355; framing error does not affect count or flags.
- Push 5 bytes, assert rst asynchronously mid-cycle -> count=0, rd_data=0, irq=0 immediately; after release, push 0x10 and pop -> 0x210.
